// File: rtl/inst_fetch_unit_pkg.sv
// ==========================================================================
// inst_fetch_unit_pkg : instruction field layout, HALT opcode, fetch FSM states
// Rev 1.0
// ==========================================================================
`default_nettype none

package inst_fetch_unit_pkg;

   localparam int unsigned INST_SIZE       = 32;
   localparam logic [5:0]  HALT_OP_DEFAULT = 6'h3F;

   // op [31:26], imm [25:12], arg3..arg0 3-bit fields packed down to bit 0
   typedef struct packed {
      logic [5:0]  op;
      logic [13:0] imm;
      logic [2:0]  arg3;
      logic [2:0]  arg2;
      logic [2:0]  arg1;
      logic [2:0]  arg0;
   } inst_fields_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } fetch_state_e;

   function automatic logic [5:0] inst_op(input logic [INST_SIZE-1:0] word);
      inst_fields_t f;
      f = inst_fields_t'(word);
      return f.op;
   endfunction

endpackage

`default_nettype wire

// File: rtl/inst_fetch_unit_skid_buffer.sv
// ==========================================================================
// inst_skid_buffer : 2-entry fall-through FIFO, valid/ready both sides, sync flush
// Rev 1.0
// ==========================================================================
`default_nettype none

module inst_skid_buffer #(
   parameter int unsigned W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush_i,
   input  logic         in_valid_i,
   output logic         in_ready_o,
   input  logic [W-1:0] in_data_i,
   output logic         out_valid_o,
   input  logic         out_ready_i,
   output logic [W-1:0] out_data_o,
   output logic [1:0]   count_o
);

   logic [W-1:0] slot_q [2];
   logic         rd_ptr_q;
   logic         wr_ptr_q;
   logic [1:0]   count_q;

   logic w_empty;
   logic w_bypass;
   logic w_push;
   logic w_pop;

   // An empty buffer passes the incoming word straight through so a
   // returning read reaches the decoder in the cycle it comes back.
   assign w_empty     = (count_q == 2'd0);
   assign in_ready_o  = (count_q != 2'd2);
   assign out_valid_o = !w_empty || in_valid_i;
   assign out_data_o  = w_empty ? in_data_i : slot_q[rd_ptr_q];
   assign w_bypass    = w_empty && out_ready_i;
   assign w_push      = in_valid_i && in_ready_o && !w_bypass;
   assign w_pop       = !w_empty && out_ready_i;
   assign count_o     = count_q;

   always_ff @(posedge clk) begin
      if (rst || flush_i) begin
         count_q  <= 2'd0;
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
      end else begin
         if (w_push) wr_ptr_q <= ~wr_ptr_q;
         if (w_pop)  rd_ptr_q <= ~rd_ptr_q;
         count_q <= count_q + {1'b0, w_push} - {1'b0, w_pop};
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) slot_q[wr_ptr_q] <= in_data_i;
   end

endmodule

`default_nettype wire

// File: rtl/inst_fetch_unit.sv
// ==========================================================================
// inst_fetch_unit : per-PE fetch (local imem, PC walk, redirect, HALT); option FETCH_LOOP_EN
// Rev 1.0
// ==========================================================================
`default_nettype none

module inst_fetch_unit
   import inst_fetch_unit_pkg::*;
#(
   parameter int unsigned DEPTH   = 64,
   parameter int unsigned AW      = $clog2(DEPTH),
   parameter logic [5:0]  HALT_OP = HALT_OP_DEFAULT
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cfg_we,
   input  logic [AW-1:0]        cfg_addr,
   input  logic [INST_SIZE-1:0] cfg_data,
   output logic                 cfg_err,
   input  logic                 start,
   input  logic                 br_valid,
   input  logic [AW-1:0]        br_target,
   output logic                 inst_valid,
   input  logic                 inst_ready,
   output logic [INST_SIZE-1:0] inst_data,
   output logic [AW-1:0]        inst_pc,
   output logic                 busy,
   output logic                 done
`ifdef FETCH_LOOP_EN
   ,
   input  logic [15:0]          loop_cnt
`endif
);

   localparam int unsigned BW = AW + INST_SIZE;

   fetch_state_e         state_q, state_d;
   logic [AW-1:0]        pc_q, pc_d;
   logic                 inflight_q;
   logic [INST_SIZE-1:0] rdata_q;
   logic [AW-1:0]        rd_pc_q;
   logic                 cfg_err_q;
   logic [INST_SIZE-1:0] mem [DEPTH];

   logic          w_redirect;
   logic          w_ret_halt;
   logic          w_loop;
   logic          w_push;
   logic          w_issue;
   logic          w_accept;
   logic          w_done;
   logic          w_buf_in_ready;
   logic          w_buf_valid;
   logic [BW-1:0] w_buf_data;
   logic [1:0]    w_buf_count;

   assign w_redirect = br_valid && (state_q != ST_IDLE);
   assign w_ret_halt = inflight_q && (inst_op(rdata_q) == HALT_OP);

`ifdef FETCH_LOOP_EN
   logic [15:0] iter_q;

   assign w_loop = w_ret_halt && (iter_q < loop_cnt);

   always_ff @(posedge clk) begin
      if (rst) begin
         iter_q <= 16'd0;
      end else if ((state_q == ST_IDLE) && start) begin
         iter_q <= 16'd0;
      end else if (w_loop && !w_redirect) begin
         iter_q <= iter_q + 16'd1;
      end
   end
`else
   assign w_loop = 1'b0;
`endif

   // Returning words are only kept in RUN; anything after HALT, or cancelled
   // by a redirect, or a looped-back HALT, is dropped here.
   assign w_push  = inflight_q && (state_q == ST_RUN) && !w_redirect && !w_loop
                    && w_buf_in_ready;
   assign w_issue = (state_q == ST_RUN) && !w_redirect && !w_ret_halt
                    && ((w_buf_count + {1'b0, inflight_q}) < 2'd2);

   assign w_accept = w_buf_valid && inst_ready;
   assign w_done   = w_accept && (state_q != ST_IDLE) && !w_redirect
                     && (inst_op(w_buf_data[INST_SIZE-1:0]) == HALT_OP);

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_RUN;
               pc_d    = '0;
            end
         end
         ST_RUN, ST_DRAIN: begin
            if (w_redirect) begin
               state_d = ST_RUN;
               pc_d    = br_target;
            end else begin
               if (w_issue) pc_d = pc_q + AW'(1);
               // A HALT that falls through and is taken at once skips DRAIN.
               if (w_loop)          pc_d    = '0;
               else if (w_done)     state_d = ST_IDLE;
               else if (w_ret_halt) state_d = ST_DRAIN;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         pc_q       <= '0;
         inflight_q <= 1'b0;
         cfg_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         inflight_q <= w_issue;
         cfg_err_q  <= cfg_we && (state_q != ST_IDLE);
      end
   end

   always_ff @(posedge clk) begin
      if (cfg_we && (state_q == ST_IDLE)) mem[cfg_addr] <= cfg_data;
      if (w_issue) begin
         rdata_q <= mem[pc_q];
         rd_pc_q <= pc_q;
      end
   end

   inst_skid_buffer #(
      .W (BW)
   ) u_skid (
      .clk         (clk),
      .rst         (rst),
      .flush_i     (w_redirect),
      .in_valid_i  (w_push),
      .in_ready_o  (w_buf_in_ready),
      .in_data_i   ({rd_pc_q, rdata_q}),
      .out_valid_o (w_buf_valid),
      .out_ready_i (inst_ready),
      .out_data_o  (w_buf_data),
      .count_o     (w_buf_count)
   );

   assign inst_valid = w_buf_valid;
   assign inst_data  = w_buf_valid ? w_buf_data[INST_SIZE-1:0] : '0;
   assign inst_pc    = w_buf_valid ? w_buf_data[BW-1:INST_SIZE] : '0;
   assign busy       = (state_q != ST_IDLE);
   assign done       = w_done;
   assign cfg_err    = cfg_err_q;

endmodule

`default_nettype wire
